// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage in-order pipeline.
// Tracks EX/MEM/WB producers, load-use stalls and the multi-cycle HI/LO unit.
module hazard_fwd_unit #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iIdValid,
  input  logic [REG_AW-1:0] iIdRs,
  input  logic [REG_AW-1:0] iIdRt,
  input  logic              iIdUseRs,
  input  logic              iIdUseRt,
  input  logic [REG_AW-1:0] iIdDst,
  input  logic              iIdRegWrite,
  input  logic              iIdIsLoad,
  input  logic              iIdUseHiLo,
  input  logic              iIdMulDiv,
  input  logic              iFlush,
  output logic              oStall,
  output logic              oBubble,
  output logic [1:0]        oFwdSelA,
  output logic [1:0]        oFwdSelB,
  output logic              oMulDivBusy
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regWrite;
    logic              isLoad;
  } stageRec_t;

  stageRec_t exRec, memRec, wbRec, idRec;
  logic [5:0] busyCnt, busyCntNext;
  logic       exHitA, memHitA, wbHitA;
  logic       exHitB, memHitB, wbHitB;
  logic       loadUse, hiLoHaz;
  logic [1:0] selA, selB;

  function automatic logic hit(
    input stageRec_t         s,
    input logic [REG_AW-1:0] x,
    input logic              en
  );
    return s.valid & s.regWrite & (s.dst == x) & (x != '0) & en;
  endfunction

  function automatic logic [1:0] pick(
    input logic ex,
    input logic ld,
    input logic mem,
    input logic wb
  );
    if (ex & !ld)  return 2'b01;
    else if (mem)  return 2'b10;
    else if (wb)   return 2'b11;
    else           return 2'b00;
  endfunction

  always_comb begin
    idRec.valid    = 1'b1;
    idRec.dst      = iIdDst;
    idRec.regWrite = iIdRegWrite;
    idRec.isLoad   = iIdIsLoad;

    exHitA  = hit(exRec,  iIdRs, iIdUseRs);
    memHitA = hit(memRec, iIdRs, iIdUseRs);
    wbHitA  = hit(wbRec,  iIdRs, iIdUseRs);
    exHitB  = hit(exRec,  iIdRt, iIdUseRt);
    memHitB = hit(memRec, iIdRt, iIdUseRt);
    wbHitB  = hit(wbRec,  iIdRt, iIdUseRt);

    selA = pick(exHitA, exRec.isLoad, memHitA, wbHitA);
    selB = pick(exHitB, exRec.isLoad, memHitB, wbHitB);

    loadUse = (exHitA | exHitB) & exRec.isLoad;
    hiLoHaz = oMulDivBusy & (iIdUseHiLo | iIdMulDiv);

    // Flush outranks any stall; reset keeps the pipe moving.
    oStall  = !iReset & iIdValid & !iFlush & (loadUse | hiLoHaz);
    oBubble = iFlush | oStall | !iIdValid;

    busyCntNext = busyCnt;
    if (iIdMulDiv & !oBubble)
      busyCntNext = 6'(MULDIV_LAT);
    else if (busyCnt != '0)
      busyCntNext = busyCnt - 6'd1;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      exRec       <= '0;
      memRec      <= '0;
      wbRec       <= '0;
      busyCnt     <= '0;
      oMulDivBusy <= 1'b0;
      oFwdSelA    <= 2'b00;
      oFwdSelB    <= 2'b00;
    end else begin
      wbRec       <= memRec;
      memRec      <= exRec;
      exRec       <= oBubble ? '0 : idRec;
      busyCnt     <= busyCntNext;
      oMulDivBusy <= busyCntNext != '0;
      oFwdSelA    <= oBubble ? 2'b00 : selA;
      oFwdSelB    <= oBubble ? 2'b00 : selB;
    end
  end

endmodule
